// File: rtl/countdown_timer_if.sv
// Control and status bundle for countdown_timer: commands and preset in,
// count and status flags out.
interface countdown_timer_if #(
  parameter int WIDTH = 6
);
  logic             LD;
  logic [WIDTH-1:0] PD;
  logic             START;
  logic             STOP;
  logic             PAUSE;
  logic             RELOAD;
  logic [WIDTH-1:0] QT;
  logic             RCO;
  logic             TC;
  logic             BUSY;
  logic             DONE;

  modport master (
    output LD, PD, START, STOP, PAUSE, RELOAD,
    input  QT, RCO, TC, BUSY, DONE
  );

  modport slave (
    input  LD, PD, START, STOP, PAUSE, RELOAD,
    output QT, RCO, TC, BUSY, DONE
  );
endinterface

// File: rtl/countdown_timer.sv
// Prescaled loadable down-counter with run/pause/stop control, one-shot or
// auto-reload modes, a terminal-count pulse and an early-warning RCO flag.
module countdown_timer #(
  parameter int WIDTH    = 6,
  parameter int PRESCALE = 1
) (
  input  logic               CLK,
  input  logic               RST,
  countdown_timer_if.slave   bus
);
  localparam int             PSW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PSW-1:0] PSLAST = PSW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] qt, qt_nx;
  logic [WIDTH-1:0] rv, rv_nx;
  logic [PSW-1:0]   ps, ps_nx;
  logic             tc, tc_nx;
  logic             busy;

  assign busy     = (state == S_RUN) || (state == S_HOLD);
  assign bus.QT   = qt;
  assign bus.TC   = tc;
  assign bus.BUSY = busy;
  assign bus.DONE = (state == S_DONE);
  assign bus.RCO  = busy && (qt == WIDTH'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      qt    <= '0;
      rv    <= '0;
      ps    <= '0;
      tc    <= 1'b0;
    end else begin
      state <= state_nx;
      qt    <= qt_nx;
      rv    <= rv_nx;
      ps    <= ps_nx;
      tc    <= tc_nx;
    end
  end

  // Command chain in priority order; a START seen while already counting
  // falls through so the RUN/HOLD handling below still applies.
  always_comb begin
    state_nx = state;
    qt_nx    = qt;
    rv_nx    = rv;
    ps_nx    = ps;
    tc_nx    = 1'b0;
    if (bus.LD) begin
      qt_nx    = bus.PD;
      rv_nx    = bus.PD;
      ps_nx    = '0;
      state_nx = S_IDLE;
    end else if (bus.STOP && busy) begin
      ps_nx    = '0;
      state_nx = S_IDLE;
    end else if (bus.START && (state == S_IDLE)) begin
      if (qt != '0) begin
        ps_nx    = '0;
        state_nx = S_RUN;
      end
    end else if (bus.START && (state == S_DONE)) begin
      qt_nx = rv;
      ps_nx = '0;
      if (rv != '0) begin
        state_nx = S_RUN;
      end
    end else if (state == S_RUN) begin
      if (bus.PAUSE) begin
        state_nx = S_HOLD;
      end else if (ps == PSLAST) begin
        ps_nx = '0;
        if (qt > WIDTH'(1)) begin
          qt_nx = qt - WIDTH'(1);
        end else if (qt == WIDTH'(1)) begin
          tc_nx = 1'b1;
          if (bus.RELOAD) begin
            qt_nx = rv;
          end else begin
            qt_nx    = '0;
            state_nx = S_DONE;
          end
        end
      end else begin
        ps_nx = ps + PSW'(1);
      end
    end else if (state == S_HOLD) begin
      // The prescaler keeps its partial period across the pause.
      if (!bus.PAUSE) begin
        state_nx = S_RUN;
      end
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench: two timers (prescale 1 and 4) share one stimulus stream
// and are compared against a cycle-level reference model plus fixed vectors.
module tb_countdown_timer;
  logic       clk;
  logic       rst;
  logic       ld, start, stop, pause, reload;
  logic [5:0] pd;

  int checks = 0;
  int errors = 0;

  countdown_timer_if #(.WIDTH(6)) b1 ();
  countdown_timer_if #(.WIDTH(6)) b4 ();

  assign b1.LD = ld;  assign b1.PD = pd;  assign b1.START = start;
  assign b1.STOP = stop;  assign b1.PAUSE = pause;  assign b1.RELOAD = reload;
  assign b4.LD = ld;  assign b4.PD = pd;  assign b4.START = start;
  assign b4.STOP = stop;  assign b4.PAUSE = pause;  assign b4.RELOAD = reload;

  countdown_timer #(.WIDTH(6), .PRESCALE(1)) u_p1 (.CLK(clk), .RST(rst), .bus(b1.slave));
  countdown_timer #(.WIDTH(6), .PRESCALE(4)) u_p4 (.CLK(clk), .RST(rst), .bus(b4.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 run, 2 hold, 3 done; 'left' counts the
  // cycles still missing in the current prescale period.
  int period [2] = '{1, 4};
  int mMode [2];
  int mQt [2];
  int mRv [2];
  int mLeft [2];
  int mTc [2];

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mMode[i] = 0; mQt[i] = 0; mRv[i] = 0; mLeft[i] = period[i]; mTc[i] = 0;
    end
  endtask

  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      mTc[i] = 0;
      if (ld) begin
        mQt[i] = pd; mRv[i] = pd; mLeft[i] = period[i]; mMode[i] = 0;
      end else if (stop && (mMode[i] == 1 || mMode[i] == 2)) begin
        mMode[i] = 0; mLeft[i] = period[i];
      end else if (start && mMode[i] == 0) begin
        if (mQt[i] != 0) begin mMode[i] = 1; mLeft[i] = period[i]; end
      end else if (start && mMode[i] == 3) begin
        mQt[i] = mRv[i]; mLeft[i] = period[i];
        if (mRv[i] != 0) mMode[i] = 1;
      end else if (mMode[i] == 1) begin
        if (pause) mMode[i] = 2;
        else begin
          mLeft[i] = mLeft[i] - 1;
          if (mLeft[i] == 0) begin
            mLeft[i] = period[i];
            if (mQt[i] > 1) mQt[i] = mQt[i] - 1;
            else if (mQt[i] == 1) begin
              mTc[i] = 1;
              if (reload) mQt[i] = mRv[i];
              else begin mQt[i] = 0; mMode[i] = 3; end
            end
          end
        end
      end else if (mMode[i] == 2) begin
        if (!pause) mMode[i] = 1;
      end
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareModel();
    int busyExp;
    for (int i = 0; i < 2; i++) begin
      busyExp = (mMode[i] == 1 || mMode[i] == 2) ? 1 : 0;
      if (i == 0) begin
        checkOutput("p1 model QT", b1.QT, mQt[0]);
        checkOutput("p1 model TC", b1.TC, mTc[0]);
        checkOutput("p1 model BUSY", b1.BUSY, busyExp);
        checkOutput("p1 model DONE", b1.DONE, (mMode[0] == 3) ? 1 : 0);
        checkOutput("p1 model RCO", b1.RCO, (busyExp == 1 && mQt[0] == 1) ? 1 : 0);
      end else begin
        checkOutput("p4 model QT", b4.QT, mQt[1]);
        checkOutput("p4 model TC", b4.TC, mTc[1]);
        checkOutput("p4 model BUSY", b4.BUSY, busyExp);
        checkOutput("p4 model DONE", b4.DONE, (mMode[1] == 3) ? 1 : 0);
        checkOutput("p4 model RCO", b4.RCO, (busyExp == 1 && mQt[1] == 1) ? 1 : 0);
      end
    end
  endtask

  task automatic applyStimulus(input logic iLd, input logic [5:0] iPd, input logic iStart,
                               input logic iStop, input logic iPause, input logic iReload);
    ld = iLd; pd = iPd; start = iStart; stop = iStop; pause = iPause; reload = iReload;
  endtask

  task automatic stepClock();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareModel();
  endtask

  typedef struct {
    logic       ld;
    logic [5:0] pd;
    logic       start;
    logic [5:0] qt;
    logic       tc;
    logic       busy;
    logic       done;
    logic       rco;
  } vec_t;

  vec_t vecs [6];
  int   lastTc;
  int   found;

  initial begin
    vecs[0] = '{ld: 1'b1, pd: 6'd3, start: 1'b0, qt: 6'd3, tc: 1'b0, busy: 1'b0, done: 1'b0, rco: 1'b0};
    vecs[1] = '{ld: 1'b0, pd: 6'd0, start: 1'b1, qt: 6'd3, tc: 1'b0, busy: 1'b1, done: 1'b0, rco: 1'b0};
    vecs[2] = '{ld: 1'b0, pd: 6'd0, start: 1'b0, qt: 6'd2, tc: 1'b0, busy: 1'b1, done: 1'b0, rco: 1'b0};
    vecs[3] = '{ld: 1'b0, pd: 6'd0, start: 1'b0, qt: 6'd1, tc: 1'b0, busy: 1'b1, done: 1'b0, rco: 1'b1};
    vecs[4] = '{ld: 1'b0, pd: 6'd0, start: 1'b0, qt: 6'd0, tc: 1'b1, busy: 1'b0, done: 1'b1, rco: 1'b0};
    vecs[5] = '{ld: 1'b0, pd: 6'd0, start: 1'b0, qt: 6'd0, tc: 1'b0, busy: 1'b0, done: 1'b1, rco: 1'b0};

    rst = 1'b1;
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    modelReset();
    @(negedge clk);
    @(negedge clk);
    compareModel();
    rst = 1'b0;

    // One-shot count 3,2,1,0 on the prescale-1 timer
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].ld, vecs[k].pd, vecs[k].start, 1'b0, 1'b0, 1'b0);
      stepClock();
      checkOutput($sformatf("vec%0d QT", k), b1.QT, vecs[k].qt);
      checkOutput($sformatf("vec%0d TC", k), b1.TC, vecs[k].tc);
      checkOutput($sformatf("vec%0d BUSY", k), b1.BUSY, vecs[k].busy);
      checkOutput($sformatf("vec%0d DONE", k), b1.DONE, vecs[k].done);
      checkOutput($sformatf("vec%0d RCO", k), b1.RCO, vecs[k].rco);
    end

    // Auto-reload on the prescale-4 timer: TC every 8 cycles, QT back to 2
    applyStimulus(1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    stepClock();
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    lastTc = 0;
    for (int k = 1; k <= 40; k++) begin
      stepClock();
      if (b4.TC) begin
        checkOutput("p4 reload period", k - lastTc, 8);
        checkOutput("p4 reload QT", b4.QT, 2);
        lastTc = k;
      end
    end
    checkOutput("p4 reload pulses", lastTc, 40);
    checkOutput("p4 reload DONE", b4.DONE, 0);

    // Pause mid-prescale on the prescale-4 timer: 2 pause edges plus the
    // resume edge delay the terminal tick from edge 20 to edge 23
    applyStimulus(1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    stepClock();
    found = -1;
    for (int k = 1; k <= 60; k++) begin
      applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, (k == 6 || k == 7), 1'b0);
      stepClock();
      if (k >= 6 && k <= 8) checkOutput("p4 hold QT", b4.QT, 4);
      if (b4.TC) begin
        found = k;
        break;
      end
    end
    checkOutput("p4 pause terminal edge", found, 23);

    // STOP at 2 then resume; START with QT=0 is ignored
    applyStimulus(1'b1, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    stepClock();
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    stepClock();
    checkOutput("stop QT", b1.QT, 2);
    checkOutput("stop BUSY", b1.BUSY, 0);
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("restart BUSY", b1.BUSY, 1);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("restart QT", b1.QT, 1);
    applyStimulus(1'b1, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("zero start BUSY", b1.BUSY, 0);
    checkOutput("zero start QT", b1.QT, 0);

    // LD on the terminal-tick edge wins; later START from DONE reloads RV=4
    applyStimulus(1'b1, 6'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("pre-terminal RCO", b1.RCO, 1);
    applyStimulus(1'b1, 6'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("ld-terminal QT", b1.QT, 4);
    checkOutput("ld-terminal TC", b1.TC, 0);
    checkOutput("ld-terminal BUSY", b1.BUSY, 0);
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) stepClock();
    checkOutput("reach DONE", b1.DONE, 1);
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    stepClock();
    checkOutput("done restart QT", b1.QT, 4);
    checkOutput("done restart BUSY", b1.BUSY, 1);

    // Randomised traffic against the model
    for (int k = 0; k < 600; k++) begin
      applyStimulus(($urandom_range(15) == 0), 6'($urandom_range(63)), ($urandom_range(3) == 0),
                    ($urandom_range(15) == 0), ($urandom_range(5) == 0), 1'($urandom_range(1)));
      stepClock();
    end

    // Asynchronous reset between edges while counting
    applyStimulus(1'b1, 6'd9, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 6'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    stepClock();
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst p1 QT", b1.QT, 0);
    checkOutput("async rst p1 BUSY", b1.BUSY, 0);
    checkOutput("async rst p1 TC", b1.TC, 0);
    checkOutput("async rst p4 QT", b4.QT, 0);
    checkOutput("async rst p4 BUSY", b4.BUSY, 0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    stepClock();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
